pram_fetch_ctrl: RTL



---
 rtl/pram_fetch_ctrl_pkg.sv | 8 +
 rtl/pram_fetch_fifo.sv | 38 +++
 rtl/pram_fetch_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/pram_fetch_ctrl_pkg.sv
// pram_fetch_ctrl_pkg: shared widths and FSM encodings for the PRAM fetch sequencer
package pram_fetch_ctrl_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 9;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_HALTING = 2'd2;
endpackage

// File: rtl/pram_fetch_fifo.sv
// pram_fetch_fifo: small synchronous prefetch FIFO; flush overrides push and pop
module pram_fetch_fifo #(
  parameter int W     = 73,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [W-1:0]             i_din,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [W-1:0]             o_head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  // pointer and occupancy bookkeeping
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= i_push ? r_wr + PW'(1) : r_wr;
      r_rd    <= i_pop ? r_rd + PW'(1) : r_rd;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
  // storage has no reset so it can map onto plain registers or RAM
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_din;
  end
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];
endmodule

// File: rtl/pram_fetch_ctrl.sv
// pram_fetch_ctrl: sequential instruction fetch from PRAM with prefetch, halt-drain and redirect
module pram_fetch_ctrl
  import pram_fetch_ctrl_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              pram_en,
  output logic              pram_rd_en,
  output logic [ADDR_W-1:0] pram_raddr,
  input  logic [DATA_W-1:0] pram_dout,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [1:0]               r_state;
  logic [ADDR_W-1:0]        r_pc, r_raddr;
  logic                     r_inflight, r_drop;
  logic [CW-1:0]            w_count;
  logic [ADDR_W+DATA_W-1:0] w_head;
  logic w_idle, w_run, w_start, w_halt, w_redir, w_issue, w_push, w_pop, w_valid, w_done;
  assign w_idle  = r_state == ST_IDLE;
  assign w_run   = r_state == ST_RUN;
  assign w_start = w_idle & start;
  assign w_halt  = w_run & halt;
  assign w_redir = w_run & redirect_valid & ~halt;
  // credit counts the in-flight read so the FIFO can never overflow
  assign w_issue = w_run & ~halt & ~redirect_valid & ((w_count + CW'(r_inflight)) < CW'(FIFO_DEPTH));
  assign w_push  = r_inflight & ~r_drop;
  assign w_valid = w_count != '0;
  assign w_pop   = w_valid & instr_ready;
  assign w_done  = (r_state == ST_HALTING) & ~r_inflight & ~w_valid;
  pram_fetch_fifo #(.W(ADDR_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (S_AXI_ACLK),
    .i_rst_n (S_AXI_ARESETN),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redir),
    .i_din   ({r_raddr, pram_dout}),
    .o_count (w_count),
    .o_head  (w_head)
  );
  // control state and program counter
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_start ? ST_RUN : w_halt ? ST_HALTING : w_done ? ST_IDLE : r_state;
      r_pc    <= w_start ? start_pc : w_redir ? redirect_pc : w_issue ? r_pc + ADDR_W'(1) : r_pc;
    end
  end
  // registered read port; the returning word is tagged with the held address
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_inflight <= 1'b0;
      r_raddr    <= '0;
      r_drop     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_raddr    <= w_issue ? r_pc : r_raddr;
      r_drop     <= w_redir & r_inflight;
    end
  end
  assign pram_en     = r_inflight;
  assign pram_rd_en  = r_inflight;
  assign pram_raddr  = r_raddr;
  assign instr_valid = w_valid;
  assign instr_data  = w_valid ? w_head[DATA_W-1:0] : '0;
  assign instr_pc    = w_valid ? w_head[ADDR_W+DATA_W-1:DATA_W] : '0;
  assign busy        = ~w_idle;
  assign done        = w_done;
endmodule
